// File: rtl/mem_responder_if.sv
// Request/response bundle between the datapath request unit, mem_responder and the RAM.
// slave is the responder's view; master is the combined requester + RAM side.
interface mem_responder_if #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              ihit;
    logic              dhit;
    logic [WORD_W-1:0] iload;
    logic [WORD_W-1:0] dload;
    logic              ram_ren;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_wdata;
    logic [WORD_W-1:0] ram_rdata;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_rdata,
        output ihit, dhit, iload, dload, ram_ren, ram_wen, ram_addr, ram_wdata
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_rdata,
        input  ihit, dhit, iload, dload, ram_ren, ram_wen, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_responder.sv
// Serialises fetch and data requests onto a single-port RAM; hit pulses WAIT_CYCLES+2 cycles
// after a request is sampled in IDLE. Requesters hold level strobes until their hit; data wins over fetch.
module mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int WORD_W      = 32,
    parameter int ADDR_W      = 32
) (
    input  logic           CLK,
    input  logic           RST,
    mem_responder_if.slave bus
);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);
    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] iload_q;
    logic [WORD_W-1:0] dload_q;
    logic              ren_q;
    logic              wen_q;
    logic              ihit_q;
    logic              dhit_q;

    // Strobes are registered on entry to ACCESS so they cover exactly WAIT_CYCLES+1 cycles;
    // wen_q doubles as the latched op, since a simultaneous dREN/dWEN is a write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= SEL_I;
            addr_q  <= '0;
            wdata_q <= '0;
            iload_q <= '0;
            dload_q <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            ihit_q  <= 1'b0;
            dhit_q  <= 1'b0;
        end else begin
            ihit_q <= 1'b0;
            dhit_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.dREN || bus.dWEN) begin
                        addr_q  <= bus.daddr;
                        wdata_q <= bus.dstore;
                        sel_q   <= SEL_D;
                        ren_q   <= ~bus.dWEN;
                        wen_q   <= bus.dWEN;
                        cnt_q   <= CNT_INIT;
                        state_q <= ACCESS;
                    end else if (bus.iREN) begin
                        addr_q  <= bus.iaddr;
                        sel_q   <= SEL_I;
                        ren_q   <= 1'b1;
                        wen_q   <= 1'b0;
                        cnt_q   <= CNT_INIT;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                        ihit_q  <= (sel_q == SEL_I);
                        dhit_q  <= (sel_q == SEL_D);
                        state_q <= RESP;
                        if (!wen_q) begin
                            if (sel_q == SEL_I) iload_q <= bus.ram_rdata;
                            else                dload_q <= bus.ram_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ihit      = ihit_q;
    assign bus.dhit      = dhit_q;
    assign bus.iload     = iload_q;
    assign bus.dload     = dload_q;
    assign bus.ram_ren   = ren_q;
    assign bus.ram_wen   = wen_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: transaction-schedule model with per-cycle compare, directed
// literal checks, a WAIT_CYCLES=0 instance, and randomized request traffic.
module tb_mem_responder;
    localparam int W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst0 = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if #(.WORD_W(32), .ADDR_W(32)) bus ();
    mem_responder_if #(.WORD_W(32), .ADDR_W(32)) bus0 ();

    mem_responder #(.WAIT_CYCLES(W), .WORD_W(32), .ADDR_W(32)) dut (
        .CLK(clk), .RST(rst), .bus(bus)
    );
    mem_responder #(.WAIT_CYCLES(0), .WORD_W(32), .ADDR_W(32)) dut0 (
        .CLK(clk), .RST(rst0), .bus(bus0)
    );

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        case (a)
            32'h40:  return 32'h8C010004;
            32'h100: return 32'hDEADBEEF;
            default: return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
        endcase
    endfunction

    assign bus.ram_rdata  = ram_word(bus.ram_addr);
    assign bus0.ram_rdata = 32'hCAFE0080;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected outputs for one clock cycle.
    typedef struct packed {
        logic        idle;
        logic        ren;
        logic        wen;
        logic        ihit;
        logic        dhit;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] iload;
        logic [31:0] dload;
    } exp_t;

    exp_t        sched[$];
    exp_t        cur = '{idle: 1'b1, default: '0};
    exp_t        rec;
    logic [31:0] m_iload = '0;
    logic [31:0] m_dload = '0;
    logic        m_isd, m_wr;
    logic [31:0] m_a;

    // Model: when idle and a request is seen, queue the whole transaction's cycle schedule.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sched.delete();
            m_iload = '0;
            m_dload = '0;
            cur = '0;
            cur.idle = 1'b1;
        end else begin
            if (cur.idle && sched.size() == 0 && (bus.dREN || bus.dWEN || bus.iREN)) begin
                m_isd = bus.dREN || bus.dWEN;
                m_wr  = bus.dWEN;
                m_a   = m_isd ? bus.daddr : bus.iaddr;
                for (int k = 0; k <= W; k++) begin
                    rec = '0;
                    rec.ren = ~m_wr;
                    rec.wen = m_wr;
                    rec.addr = m_a;
                    rec.wdata = bus.dstore;
                    rec.iload = m_iload;
                    rec.dload = m_dload;
                    sched.push_back(rec);
                end
                if (!m_wr) begin
                    if (m_isd) m_dload = ram_word(m_a);
                    else       m_iload = ram_word(m_a);
                end
                rec = '0;
                rec.ihit = ~m_isd;
                rec.dhit = m_isd;
                rec.iload = m_iload;
                rec.dload = m_dload;
                sched.push_back(rec);
            end
            if (sched.size() > 0) begin
                cur = sched.pop_front();
            end else begin
                cur = '0;
                cur.idle = 1'b1;
                cur.iload = m_iload;
                cur.dload = m_dload;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ren", bus.ram_ren, 0);
            chk("rst_wen", bus.ram_wen, 0);
            chk("rst_hits", {bus.ihit, bus.dhit}, 0);
            chk("rst_iload", bus.iload, 0);
            chk("rst_dload", bus.dload, 0);
            chk("rst_addr", bus.ram_addr, 0);
            chk("rst_wdata", bus.ram_wdata, 0);
        end else begin
            chk("ram_ren", bus.ram_ren, cur.ren);
            chk("ram_wen", bus.ram_wen, cur.wen);
            chk("ihit", bus.ihit, cur.ihit);
            chk("dhit", bus.dhit, cur.dhit);
            chk("iload", bus.iload, cur.iload);
            chk("dload", bus.dload, cur.dload);
            if (cur.ren || cur.wen) chk("ram_addr", bus.ram_addr, cur.addr);
            if (cur.wen) chk("ram_wdata", bus.ram_wdata, cur.wdata);
        end
    end

    int n_ren, n_wen, n_ih, n_dh, lat;

    // Starts a request just after a posedge; k counts negedges, k=0 lying in the sampling cycle.
    task automatic run_req(input logic i, input logic dr, input logic dw,
                           input logic [31:0] a, input logic [31:0] wd);
        n_ren = 0; n_wen = 0; n_ih = 0; n_dh = 0; lat = -1;
        bus.iREN = i; bus.iaddr = a; bus.dREN = dr; bus.dWEN = dw;
        bus.daddr = a; bus.dstore = wd;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (bus.ram_ren) n_ren++;
            if (bus.ram_wen) n_wen++;
            if (bus.ram_ren || bus.ram_wen) chk("req_addr", bus.ram_addr, a);
            if (bus.ram_wen) chk("req_wdata", bus.ram_wdata, wd);
            if (bus.ihit || bus.dhit) begin
                if (lat < 0) lat = k;
                n_ih += int'(bus.ihit);
                n_dh += int'(bus.dhit);
                bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
            end
        end
    endtask

    initial begin
        bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0; bus.daddr = 0; bus.dstore = 0;
        bus0.iREN = 1; bus0.iaddr = 32'h80; bus0.dREN = 0; bus0.dWEN = 0;
        bus0.daddr = 0; bus0.dstore = 0;
        repeat (2) @(posedge clk);

        // WAIT_CYCLES=0: continuous fetch, hit every 3 cycles starting at k=2.
        #1 rst0 = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk("w0_ihit", bus0.ihit, (k >= 2 && (k - 2) % 3 == 0));
            chk("w0_ren", bus0.ram_ren, (k % 3 == 1));
            chk("w0_iload", bus0.iload, (k >= 2) ? 32'hCAFE0080 : 32'h0);
            if (bus0.ram_ren) chk("w0_addr", bus0.ram_addr, 32'h80);
        end
        bus0.iREN = 1'b0;

        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        run_req(1, 0, 0, 32'h40, 32'h0);
        chk("fetch_ren_cycles", n_ren, 3);
        chk("fetch_latency", lat, 4);
        chk("fetch_ihits", n_ih, 1);
        chk("fetch_iload", bus.iload, 32'h8C010004);

        @(posedge clk); #1;
        bus.iREN = 1; bus.iaddr = 32'h40; bus.dREN = 1; bus.daddr = 32'h100;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.ihit || bus.dhit) break;
        end
        chk("simul_dhit_first", bus.dhit, 1);
        chk("simul_no_ihit", bus.ihit, 0);
        chk("simul_dload", bus.dload, 32'hDEADBEEF);
        bus.dREN = 0;
        lat = -1;
        for (int k = 1; k < 12; k++) begin
            @(negedge clk);
            if (bus.ihit) begin lat = k; break; end
        end
        chk("simul_ihit_delay", lat, 5);
        chk("simul_iload", bus.iload, 32'h8C010004);
        bus.iREN = 0;

        @(posedge clk); #1;
        run_req(0, 0, 1, 32'h200, 32'h12345678);
        chk("write_wen_cycles", n_wen, W + 1);
        chk("write_ren_cycles", n_ren, 0);
        chk("write_dhits", n_dh, 1);
        chk("write_dload_kept", bus.dload, 32'hDEADBEEF);

        @(posedge clk); #1;
        run_req(0, 1, 1, 32'h100, 32'hA5A5A5A5);
        chk("both_wen_cycles", n_wen, W + 1);
        chk("both_ren_cycles", n_ren, 0);
        chk("both_dhits", n_dh, 1);
        chk("both_dload_kept", bus.dload, 32'hDEADBEEF);

        // Reset in the second ACCESS cycle.
        @(posedge clk); #1;
        bus.dREN = 1; bus.daddr = 32'h300;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1; bus.dREN = 0;
        #1;
        chk("arst_ren", bus.ram_ren, 0);
        chk("arst_hits", {bus.ihit, bus.dhit}, 0);
        chk("arst_iload", bus.iload, 0);
        chk("arst_dload", bus.dload, 0);
        chk("arst_addr", bus.ram_addr, 0);
        @(posedge clk); #1 rst = 1'b0;
        n_ih = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_ih += int'(bus.ihit) + int'(bus.dhit);
        end
        chk("arst_no_hit", n_ih, 0);
        @(posedge clk); #1;
        run_req(1, 0, 0, 32'h40, 32'h0);
        chk("post_rst_latency", lat, 4);
        chk("post_rst_iload", bus.iload, 32'h8C010004);

        // Random traffic, with occasional asynchronous resets.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 99) == 0);
            bus.iREN = ($urandom_range(0, 2) != 0);
            bus.dREN = ($urandom_range(0, 2) == 0);
            bus.dWEN = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: bus.daddr = 32'h40;
                1: bus.daddr = 32'h100;
                2: bus.daddr = 32'h200;
                default: bus.daddr = $urandom & 32'hFFFF_FFFC;
            endcase
            bus.iaddr  = $urandom & 32'h0000_0FFC;
            bus.dstore = $urandom;
        end
        @(posedge clk); #1;
        rst = 1'b0; bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
        repeat (10) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the datapath request interface. It accepts instruction-fetch and data read/write requests, serialises them onto a single-port RAM with a fixed, parameterised access latency, and returns one-cycle `ihit`/`dhit` pulses with load data. The datapath request unit holds its data strobes until `dhit` and re-arms them on `ihit`. This block answers those strobes and sits between that unit and main memory.

## Interface
Parameters:
- `WAIT_CYCLES`, 2: extra RAM access cycles beyond the first; legal range 0–15.
- `WORD_W`, 32: data word width.
- `ADDR_W`, 32: byte address width.

Ports:
- `CLK`  in  1  sole clock; all state changes on its rising edge.
- `RST`  in  1  reset. Asynchronous and active-high: one clock; reset is asynchronous and active-high.
- `iREN`  in  1  instruction fetch request (level).
- `iaddr`  in  ADDR_W  fetch address.
- `dREN`  in  1  data read request (level).
- `dWEN`  in  1  data write request (level).
- `daddr`  in  ADDR_W  data address.
- `dstore`  in  WORD_W  write data.
- `ihit`  out  1  one-cycle pulse: fetch complete, `iload` valid.
- `dhit`  out  1  one-cycle pulse: data access complete, `dload` valid for reads.
- `iload`  out  WORD_W  fetched word (registered, held until next fetch).
- `dload`  out  WORD_W  read word (registered, held until next data read).
- `ram_ren`  out  1  RAM read strobe.
- `ram_wen`  out  1  RAM write strobe.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wdata`  out  WORD_W  RAM write data.
- `ram_rdata`  in  WORD_W  RAM read data, valid by the last access cycle.

## Operation
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - if `dREN|dWEN`, latch `daddr`, `dstore` and op into `sel=D`, then go to ACCESS with `cnt=WAIT_CYCLES`.
  - else if `iREN`, latch `iaddr` with `sel=I` and op=read, then go to ACCESS.
  - else stay in IDLE.
- Priority: data requests always win over fetch requests.
- `dWEN` and `dREN` both high is treated as a write. The read is dropped and only one `dhit` is issued.
- ACCESS:
  - `ram_addr` and `ram_wdata` are driven from the latches.
  - `ram_ren` is high for a read; `ram_wen` is high for a write.
  - Input changes are ignored.
  - If `cnt==0`, go to RESP. On a read, capture `ram_rdata` into `iload` or `dload` according to `sel`.
  - Otherwise decrement `cnt`.
- RESP:
  - `ihit` is high if `sel=I`; `dhit` is high if `sel=D`.
  - RAM strobes are low.
  - Go to IDLE unconditionally.
- Requesters clear their strobes at the same edge that samples the hit, so no extra recovery state is needed.
- `cnt` is ceil(log2(WAIT_CYCLES+1)) bits (minimum 1) and never wraps.

## Timing
- A request first sampled in IDLE at edge N:
  - ACCESS occupies cycles N+1 … N+1+WAIT_CYCLES.
  - The hit is high in cycle N+2+WAIT_CYCLES.
  - With the default parameters, the hit comes 4 cycles after the request.
- Back-to-back requests: IDLE re-samples in the cycle after RESP. Throughput is one access per WAIT_CYCLES+3 cycles.
- `ihit` and `dhit` are never high in the same cycle, and each is exactly one cycle wide.
- `iload`/`dload` update at the edge entering RESP and are stable while the hit is high.
- A write does not modify `dload`.
- Reset values: state IDLE, `cnt=0`, `sel=I`, all latches 0.
  - Outputs: `ihit=dhit=ram_ren=ram_wen=0`; `iload`, `dload`, `ram_addr`, `ram_wdata` all 0.
- Reset asserted mid-ACCESS or in RESP:
  - Strobes and hits drop immediately (asynchronous).
  - The in-flight access is discarded and no hit is issued after reset is released.
- Once accepted, a request dropped during ACCESS still completes and still pulses its hit.

## Test plan
- Fetch only, WAIT_CYCLES=2:
  - Stimulus: `iREN=1`, `iaddr=0x40`, RAM returns 0x8C010004.
  - Required: `ram_ren` high for 3 cycles with `ram_addr=0x40`; `ihit` is a single pulse 4 cycles after the request; `iload=0x8C010004`.
- Simultaneous requests:
  - Stimulus: `iREN=dREN=1`, `daddr=0x100`, RAM returns 0xDEADBEEF.
  - Required: `dhit` comes first with `dload=0xDEADBEEF`. After the bench drops `dREN`, `ihit` follows 4 cycles after IDLE.
- Write:
  - Stimulus: `dWEN=1`, `daddr=0x200`, `dstore=0x12345678`.
  - Required: `ram_wen=1` with that address and data for WAIT_CYCLES+1 cycles; `ram_ren=0`; one `dhit`; `dload` unchanged.
- Both data strobes:
  - Stimulus: `dREN=dWEN=1`.
  - Required: write only, exactly one `dhit`.
- Reset mid-operation:
  - Stimulus: assert `RST` in the second ACCESS cycle.
  - Required: all outputs 0 immediately; no hit after release; a new request then completes with normal latency.
- WAIT_CYCLES=0 sweep:
  - Stimulus: continuous `iREN`.
  - Required: an `ihit` pulse every 3 cycles, first one 2 cycles after the request.
